// File: rtl/tanimoto_pkg.sv
// Shared tanimoto parameters and width derivations, so the top and the
// ID-pair packer agree on pair and word geometry.
package tanimoto_pkg;

    localparam int unsigned VEC_ID_WIDTH_DEF = 10;
    localparam int unsigned BUS_WIDTH_DEF    = 512;

    function automatic int unsigned pair_width(input int unsigned vec_id_width);
        return 2 * vec_id_width;
    endfunction

    function automatic int unsigned pairs_per_word(input int unsigned bus_width,
                                                   input int unsigned vec_id_width);
        return bus_width / pair_width(vec_id_width);
    endfunction

    function automatic int unsigned slot_cnt_width(input int unsigned bus_width,
                                                   input int unsigned vec_id_width);
        return $clog2(pairs_per_word(bus_width, vec_id_width) + 1);
    endfunction

endpackage

// File: rtl/idpair_packer_if.sv
// Pair-FIFO input side and packed-word output stream of idpair_packer.
// master = packer side, slave = FIFO/DMA environment side.
interface idpair_packer_if #(
    parameter int unsigned BUS_WIDTH    = tanimoto_pkg::BUS_WIDTH_DEF,
    parameter int unsigned VEC_ID_WIDTH = tanimoto_pkg::VEC_ID_WIDTH_DEF
);
    localparam int unsigned PAIR_WIDTH     = tanimoto_pkg::pair_width(VEC_ID_WIDTH);
    localparam int unsigned SLOT_CNT_WIDTH = tanimoto_pkg::slot_cnt_width(BUS_WIDTH, VEC_ID_WIDTH);

    logic                      i_IDPair_Ready;
    logic [PAIR_WIDTH-1:0]     i_IDPair;
    logic                      i_IDPair_Last;
    logic                      o_IDPair_Read;
    logic [BUS_WIDTH-1:0]      o_Data;
    logic                      o_Valid;
    logic                      i_Ready;
    logic [SLOT_CNT_WIDTH-1:0] o_PairCnt;
    logic                      o_Last;
    logic [31:0]               o_PairTotal;

    modport master (
        input  i_IDPair_Ready, i_IDPair, i_IDPair_Last, i_Ready,
        output o_IDPair_Read, o_Data, o_Valid, o_PairCnt, o_Last, o_PairTotal
    );

    modport slave (
        output i_IDPair_Ready, i_IDPair, i_IDPair_Last, i_Ready,
        input  o_IDPair_Read, o_Data, o_Valid, o_PairCnt, o_Last, o_PairTotal
    );

endinterface

// File: rtl/idpair_packer.sv
// Packs (ref, cmp) ID pairs densely into BUS_WIDTH words for the host DMA;
// a job's last pair flushes the partial word. Keeps a per-job pair total.
module idpair_packer
    import tanimoto_pkg::*;
#(
    parameter int unsigned BUS_WIDTH    = BUS_WIDTH_DEF,
    parameter int unsigned VEC_ID_WIDTH = VEC_ID_WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rstn,
    idpair_packer_if.master bus
);

    localparam int unsigned PAIR_WIDTH     = pair_width(VEC_ID_WIDTH);
    localparam int unsigned PAIRS_PER_WORD = pairs_per_word(BUS_WIDTH, VEC_ID_WIDTH);
    localparam int unsigned SLOT_CNT_WIDTH = slot_cnt_width(BUS_WIDTH, VEC_ID_WIDTH);
    localparam logic [SLOT_CNT_WIDTH-1:0] LAST_SLOT = SLOT_CNT_WIDTH'(PAIRS_PER_WORD - 1);

    logic [BUS_WIDTH-1:0]      acc;
    logic [BUS_WIDTH-1:0]      acc_merged;
    logic [SLOT_CNT_WIDTH-1:0] slot;
    logic                      job_done;
    logic                      out_free;
    logic                      completing;
    logic                      accept;

    assign out_free   = !bus.o_Valid || bus.i_Ready;
    assign completing = (slot == LAST_SLOT) || bus.i_IDPair_Last;
    // Only a word-completing pair needs room in the output register.
    assign accept     = rstn && bus.i_IDPair_Ready && (!completing || out_free);
    assign bus.o_IDPair_Read = accept;

    always_comb begin
        acc_merged = acc;
        for (int unsigned k = 0; k < PAIRS_PER_WORD; k++) begin
            if (slot == SLOT_CNT_WIDTH'(k)) begin
                acc_merged[k*PAIR_WIDTH +: PAIR_WIDTH] = bus.i_IDPair;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc             <= '0;
            slot            <= '0;
            job_done        <= 1'b0;
            bus.o_Data      <= '0;
            bus.o_Valid     <= 1'b0;
            bus.o_PairCnt   <= '0;
            bus.o_Last      <= 1'b0;
            bus.o_PairTotal <= '0;
        end else begin
            if (bus.o_Valid && bus.i_Ready) begin
                bus.o_Valid <= 1'b0;
            end
            if (accept) begin
                if (completing) begin
                    bus.o_Data    <= acc_merged;
                    bus.o_Valid   <= 1'b1;
                    bus.o_PairCnt <= slot + SLOT_CNT_WIDTH'(1);
                    bus.o_Last    <= bus.i_IDPair_Last;
                    acc           <= '0;
                    slot          <= '0;
                end else begin
                    acc  <= acc_merged;
                    slot <= slot + SLOT_CNT_WIDTH'(1);
                end
                // Total restarts on the first pair after a Last, and saturates.
                job_done <= bus.i_IDPair_Last;
                if (job_done) begin
                    bus.o_PairTotal <= 32'd1;
                end else if (bus.o_PairTotal != '1) begin
                    bus.o_PairTotal <= bus.o_PairTotal + 32'd1;
                end
            end
        end
    end

endmodule

// File: doc/idpair_packer.md
# idpair_packer

Downstream stage of `tanimoto_top`. It pops `(ref ID, cmp ID)` pairs from the tanimoto ID-pair output FIFO and packs them densely into `BUS_WIDTH`-bit words. It presents those words on a valid/ready stream towards the host write-back DMA. A partial word is flushed when the job's last pair arrives, and a per-job pair total is maintained for the host.

## Interface

Parameters:
- `BUS_WIDTH`, 512 — output word width.
- `VEC_ID_WIDTH`, 10 — width of one vector ID.
- `PAIR_WIDTH`, `2*VEC_ID_WIDTH` — derived; not overridable.
- `PAIRS_PER_WORD`, `BUS_WIDTH/PAIR_WIDTH` — derived (25 at defaults).
- `SLOT_CNT_WIDTH`, `$clog2(PAIRS_PER_WORD+1)` — derived.

Ports:
- `clk` — in, 1 — single clock.
- `rstn` — in, 1 — reset; asynchronous, active-low.
- `i_IDPair_Ready` — in, 1 — upstream FIFO non-empty (first-word fall-through).
- `i_IDPair` — in, `PAIR_WIDTH` — head pair; valid while `i_IDPair_Ready`=1.
- `i_IDPair_Last` — in, 1 — head pair is the job's final pair.
- `o_IDPair_Read` — out, 1 — pop strobe; the pair is consumed on this clock edge.
- `o_Data` — out, `BUS_WIDTH` — packed word.
- `o_Valid` — out, 1 — `o_Data` holds a word.
- `i_Ready` — in, 1 — downstream accepts the word when `o_Valid && i_Ready`.
- `o_PairCnt` — out, `SLOT_CNT_WIDTH` — number of valid pairs in `o_Data`, range 1..`PAIRS_PER_WORD`.
- `o_Last` — out, 1 — the word ends the job.
- `o_PairTotal` — out, 32 — pairs accepted in the current/last job.

## Operation

- Accumulator `acc` (`BUS_WIDTH`) and slot counter `slot` (0..`PAIRS_PER_WORD-1`).
- Accepted pair k of a word is written to `acc[k*PAIR_WIDTH +: PAIR_WIDTH]`. `i_IDPair` is stored verbatim.
- Bits above `PAIRS_PER_WORD*PAIR_WIDTH`, and all unfilled slots, are 0 in every emitted word.
- Output register holds `o_Data`/`o_Valid`/`o_PairCnt`/`o_Last`.
  - `out_free = !o_Valid || i_Ready`.
- Completing accept: `slot == PAIRS_PER_WORD-1` or `i_IDPair_Last`.
- `o_IDPair_Read = i_IDPair_Ready && (!completing || out_free)`. This is combinational; stalls happen only on completing pairs.
- Non-completing accept: write the slot, `slot++`.
- Completing accept:
  - the output register loads `acc` with the current pair merged in;
  - `o_PairCnt = slot+1`, `o_Last = i_IDPair_Last`;
  - `acc` clears and `slot` returns to 0.
- Output handshake:
  - `o_Valid` clears on `o_Valid && i_Ready` unless a completing accept reloads it in the same cycle;
  - a simultaneous drain and load gives back-to-back words.
- `o_PairTotal`:
  - increments on each accept;
  - on the first accept after a Last-accept it restarts at 1;
  - it holds its value after Last until then; saturates at 2^32-1.
- No state machine beyond `slot`/`o_Valid`. There is no timeout flush: only Last or a full word emits.

## Timing

- Reset (`rstn`=0, asynchronous) sets:
  - `o_Valid`, `o_Last`, `o_PairCnt`, `o_Data`, `o_PairTotal`, `acc`, `slot` to 0;
  - `o_IDPair_Read` to 0, because it is gated by the registered state and by `rstn`.
- Reset mid-word discards the partial `acc` and any held output word.
- Latency: a completing pair accepted at edge N gives `o_Valid`=1 after edge N.
- Throughput: one pair per cycle sustained while `i_Ready`=1.
- `o_Data`, `o_PairCnt` and `o_Last` are stable while `o_Valid && !i_Ready`.
- When `i_IDPair_Ready`=0, nothing changes except output drain.
- Last on slot 0 emits a 1-pair word. Last on slot `PAIRS_PER_WORD-1` emits one full word with `o_Last`=1; no empty word follows.

## Structure

- The shared package `tanimoto_pkg` holds `VEC_ID_WIDTH` defaults and the `PAIR_WIDTH` / `PAIRS_PER_WORD` derivation functions, so that `tanimoto_top` and the packer agree.
- A single module; no sub-module needed. The output register stays inline.

## Test plan

Defaults throughout (25 pairs/word).

1. 25 pairs back-to-back, IDs pair k = `{ref=k, cmp=k+100}`, `i_Ready`=1:
   - exactly one word, `o_PairCnt`=25, `o_Last`=0;
   - `o_Data[19:0]` = `{10'd0,10'd100}`;
   - `o_Data[511:500]`=0.
2. 3 pairs with Last on the third:
   - one word, `o_PairCnt`=3, `o_Last`=1;
   - `o_Data[511:60]`=0;
   - `o_PairTotal`=3.
3. 50 pairs with `i_Ready`=0 until cycle 60:
   - `o_IDPair_Read` drops on the 50th pair and stays 0;
   - after release, two words in order with no pair lost or duplicated.
4. Last on the 25th pair, then a second job of 1 pair:
   - first word `o_PairCnt`=25, `o_Last`=1;
   - second word `o_PairCnt`=1, `o_Last`=1;
   - `o_PairTotal` reads 25, then 1.
5. Assert `rstn`=0 asynchronously after 10 pairs:
   - all outputs go to 0 immediately;
   - the next 25 pairs form a word starting at slot 0.
6. Random `i_IDPair_Ready`/`i_Ready` throttling over 1000 pairs with random Last:
   - a scoreboard confirms order, counts, zero padding and `o_Last` placement.
